imem_loader: RTL

- Writer side of the instruction memory. Accepts a byte stream with a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes each word into the instruction RAM at sequential word-aligned byte addresses, starting at 0.
- Holds the fetch pipeline (PC write and IF/ID write disabled) while loading, then pulses a PC restart so fetch begins again at address 0.
- Replaces the file-based preload with a runtime programming path.

---
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: assembles a length-prefixed, XOR-checksummed
// byte stream into 32-bit words, writes them from address 0 and holds the core meanwhile.
module imem_loader #(
  parameter int DEPTH = 79,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        pc_restart,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         len_lo_r, len_lo_s;
  logic [CNT_W-1:0]   len_r, len_s;
  logic [CNT_W-1:0]   word_idx_r, word_idx_s;
  logic [1:0]         lane_r, lane_s;
  logic [23:0]        word_buf_r, word_buf_s;
  logic [7:0]         chk_r, chk_s;
  logic               byte_ready_r, byte_ready_s;
  logic               wr_en_r, wr_en_s;
  logic [31:0]        wr_addr_r, wr_addr_s;
  logic [31:0]        wr_data_r, wr_data_s;
  logic               cpu_hold_r, cpu_hold_s;
  logic               pc_restart_r, pc_restart_s;
  logic               done_r, done_s;
  logic               error_r, error_s;
  logic               accept_s;
  logic [CNT_W-1:0]   n_s;

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_s      = state_r;
    len_lo_s     = len_lo_r;
    len_s        = len_r;
    word_idx_s   = word_idx_r;
    lane_s       = lane_r;
    word_buf_s   = word_buf_r;
    chk_s        = chk_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    cpu_hold_s   = cpu_hold_r;
    pc_restart_s = 1'b0;
    done_s       = done_r;
    error_s      = error_r;
    accept_s     = byte_valid && byte_ready_r;
    n_s          = CNT_W'({byte_data, len_lo_r});

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_s    = ST_LEN_LO;
          cpu_hold_s = 1'b1;
          done_s     = 1'b0;
          error_s    = 1'b0;
          chk_s      = 8'h00;
          word_idx_s = '0;
          lane_s     = 2'd0;
        end else begin
          state_s    = state_r;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_lo_s = byte_data;
          state_s  = ST_LEN_HI;
        end else begin
          state_s  = state_r;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_s = n_s;
          if (n_s > CNT_W'(DEPTH)) begin
            state_s = ST_ERR;
            error_s = 1'b1;
          end else if (n_s == '0) begin
            state_s = ST_CHK;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          chk_s = chk_update(chk_r, byte_data);
          case (lane_r)
            2'd0:    word_buf_s[7:0]   = byte_data;
            2'd1:    word_buf_s[15:8]  = byte_data;
            2'd2:    word_buf_s[23:16] = byte_data;
            default: word_buf_s        = word_buf_r;
          endcase
          // The fourth byte completes the word: write it straight from the buffer.
          if (lane_r == 2'd3) begin
            wr_en_s    = 1'b1;
            wr_data_s  = {byte_data, word_buf_r};
            wr_addr_s  = 32'(word_idx_r) << 2;
            word_idx_s = word_idx_r + CNT_W'(1);
            lane_s     = 2'd0;
            if (word_idx_r + CNT_W'(1) == len_r) begin
              state_s = ST_CHK;
            end else begin
              state_s = state_r;
            end
          end else begin
            lane_s = lane_r + 2'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          if (byte_data == chk_r) begin
            state_s      = ST_DONE;
            pc_restart_s = 1'b1;
            cpu_hold_s   = 1'b0;
            done_s       = 1'b1;
          end else begin
            state_s      = ST_ERR;
            error_s      = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    byte_ready_s = (state_s == ST_LEN_LO) || (state_s == ST_LEN_HI) ||
                   (state_s == ST_DATA)   || (state_s == ST_CHK);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      len_lo_r     <= 8'h00;
      len_r        <= '0;
      word_idx_r   <= '0;
      lane_r       <= 2'd0;
      word_buf_r   <= 24'h000000;
      chk_r        <= 8'h00;
      byte_ready_r <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= 32'h00000000;
      wr_data_r    <= 32'h00000000;
      cpu_hold_r   <= 1'b0;
      pc_restart_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_lo_r     <= len_lo_s;
      len_r        <= len_s;
      word_idx_r   <= word_idx_s;
      lane_r       <= lane_s;
      word_buf_r   <= word_buf_s;
      chk_r        <= chk_s;
      byte_ready_r <= byte_ready_s;
      wr_en_r      <= wr_en_s;
      wr_addr_r    <= wr_addr_s;
      wr_data_r    <= wr_data_s;
      cpu_hold_r   <= cpu_hold_s;
      pc_restart_r <= pc_restart_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  assign byte_ready = byte_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign cpu_hold   = cpu_hold_r;
  assign pc_restart = pc_restart_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
